// File: rtl/soc_bus_fabric_pkg.sv
// Shared types and limits for the host/device bus fabric and its response tracker.
package soc_bus_fabric_pkg;

    localparam int MaxHosts    = 8;
    localparam int MaxDevices  = 16;
    localparam int MaxDepth    = 16;
    localparam int HostIdxW    = $clog2(MaxHosts);
    localparam int DevIdxW     = $clog2(MaxDevices);
    localparam int DepthIdxW   = $clog2(MaxDepth);

    typedef struct packed {
        logic [HostIdxW-1:0] host;
        logic [DevIdxW-1:0]  dev;
        logic                dec_err;
    } rsp_entry_t;

    localparam int RspEntryW = $bits(rsp_entry_t);

    function automatic logic addr_match(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] mask
    );
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/bus_rsp_fifo.sv
// In-order response tracker: one entry per granted request, head visible combinationally.
module bus_rsp_fifo
    import soc_bus_fabric_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  rsp_entry_t entry_i,
    input  logic       pop_i,
    output rsp_entry_t head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    rsp_entry_t      r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign full_o  = (r_count == (PtrW+1)'(Depth));
    assign empty_o = (r_count == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign head_o  = r_mem[r_rd_ptr];

    // Storage carries no reset; validity is tracked purely by the count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= entry_i;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/soc_bus_fabric.sv
// Multi-host to multi-device bus fabric: round-robin grant, mask/base decode, in-order responses.
module soc_bus_fabric
    import soc_bus_fabric_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int NrDevices      = 8,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    host_req_i    [NrHosts],
    output logic                    host_gnt_o    [NrHosts],
    input  logic [AddressWidth-1:0] host_addr_i   [NrHosts],
    input  logic                    host_we_i     [NrHosts],
    input  logic [DataWidth/8-1:0]  host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i  [NrHosts],
    output logic                    host_rvalid_o [NrHosts],
    output logic [DataWidth-1:0]    host_rdata_o  [NrHosts],
    output logic                    host_err_o    [NrHosts],

    output logic                    device_req_o    [NrDevices],
    output logic [AddressWidth-1:0] device_addr_o   [NrDevices],
    output logic                    device_we_o     [NrDevices],
    output logic [DataWidth/8-1:0]  device_be_o     [NrDevices],
    output logic [DataWidth-1:0]    device_wdata_o  [NrDevices],
    input  logic                    device_rvalid_i [NrDevices],
    input  logic [DataWidth-1:0]    device_rdata_i  [NrDevices],
    input  logic                    device_err_i    [NrDevices],

    input  logic [AddressWidth-1:0] cfg_device_addr_base_i [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask_i [NrDevices]
);

    localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic [HostW-1:0]        r_last_host;

    logic                    w_any_req;
    logic [HostW-1:0]        w_sel_host;
    logic                    w_grant;
    logic [AddressWidth-1:0] w_sel_addr;
    logic                    w_sel_we;
    logic [DataWidth/8-1:0]  w_sel_be;
    logic [DataWidth-1:0]    w_sel_wdata;
    logic                    w_dev_hit;
    logic [DevW-1:0]         w_dev_idx;
    logic                    w_dev_req [NrDevices];

    rsp_entry_t              w_push_entry;
    rsp_entry_t              w_head;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic                    w_head_dev_rvalid;
    logic [DataWidth-1:0]    w_head_dev_rdata;
    logic                    w_head_dev_err;
    logic                    w_rsp_valid;
    logic [DataWidth-1:0]    w_rsp_data;
    logic                    w_rsp_err;

    // Round-robin search starting just after the last granted host.
    always_comb begin
        int idx;
        idx        = 0;
        w_any_req  = 1'b0;
        w_sel_host = '0;
        for (int i = 0; i < NrHosts; i++) begin
            idx = int'(r_last_host) + 1 + i;
            if (idx >= NrHosts) begin
                idx = idx - NrHosts;
            end
            if (!w_any_req && host_req_i[idx]) begin
                w_any_req  = 1'b1;
                w_sel_host = HostW'(idx);
            end
        end
    end

    // Tracker full blocks the grant even if a pop happens this cycle.
    assign w_grant     = w_any_req && !w_fifo_full && !rst_i;
    assign w_sel_addr  = host_addr_i[w_sel_host];
    assign w_sel_we    = host_we_i[w_sel_host];
    assign w_sel_be    = host_be_i[w_sel_host];
    assign w_sel_wdata = host_wdata_i[w_sel_host];

    always_comb begin
        w_dev_hit = 1'b0;
        w_dev_idx = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!w_dev_hit && addr_match(64'(w_sel_addr),
                                         64'(cfg_device_addr_base_i[d]),
                                         64'(cfg_device_addr_mask_i[d]))) begin
                w_dev_hit = 1'b1;
                w_dev_idx = DevW'(d);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NrDevices; gi++) begin : g_dev
            assign w_dev_req[gi]      = w_grant && w_dev_hit && (w_dev_idx == DevW'(gi));
            assign device_req_o[gi]   = w_dev_req[gi];
            assign device_addr_o[gi]  = w_dev_req[gi] ? w_sel_addr  : '0;
            assign device_we_o[gi]    = w_dev_req[gi] ? w_sel_we    : 1'b0;
            assign device_be_o[gi]    = w_dev_req[gi] ? w_sel_be    : '0;
            assign device_wdata_o[gi] = w_dev_req[gi] ? w_sel_wdata : '0;
        end
    endgenerate

    assign w_push_entry.host    = HostIdxW'(w_sel_host);
    assign w_push_entry.dev     = DevIdxW'(w_dev_idx);
    assign w_push_entry.dec_err = !w_dev_hit;

    bus_rsp_fifo #(
        .Depth (MaxOutstanding)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_grant),
        .entry_i (w_push_entry),
        .pop_i   (w_rsp_valid),
        .head_o  (w_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Only the device named by the head entry may complete a response.
    always_comb begin
        w_head_dev_rvalid = 1'b0;
        w_head_dev_rdata  = '0;
        w_head_dev_err    = 1'b0;
        for (int d = 0; d < NrDevices; d++) begin
            if (w_head.dev == DevIdxW'(d)) begin
                w_head_dev_rvalid = device_rvalid_i[d];
                w_head_dev_rdata  = device_rdata_i[d];
                w_head_dev_err    = device_err_i[d];
            end
        end
    end

    assign w_rsp_valid = !rst_i && !w_fifo_empty && (w_head.dec_err || w_head_dev_rvalid);
    assign w_rsp_data  = w_head.dec_err ? '0 : w_head_dev_rdata;
    assign w_rsp_err   = w_head.dec_err ? 1'b1 : w_head_dev_err;

    generate
        for (genvar gi = 0; gi < NrHosts; gi++) begin : g_host
            logic w_mine;
            assign w_mine            = w_rsp_valid && (w_head.host == HostIdxW'(gi));
            assign host_gnt_o[gi]    = w_grant && (w_sel_host == HostW'(gi));
            assign host_rvalid_o[gi] = w_mine;
            assign host_rdata_o[gi]  = w_mine ? w_rsp_data : '0;
            assign host_err_o[gi]    = w_mine ? w_rsp_err  : 1'b0;
        end
    endgenerate

    // Resetting to the last host makes host 0 first in the search order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_host <= HostW'(NrHosts - 1);
        end else if (w_grant) begin
            r_last_host <= w_sel_host;
        end
    end

endmodule

// File: doc/soc_bus_fabric.md
SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 SHALL have parameter NrHosts, default 2: number of host ports, legal range 1..8.
REQ-002 SHALL have parameter NrDevices, default 8: number of device ports, legal range 1..16.
REQ-003 SHALL have parameter DataWidth, default 32: data bus width.
REQ-004 SHALL have parameter AddressWidth, default 32: address width.
REQ-005 SHALL have parameter MaxOutstanding, default 4: response-tracking depth, a power of 2, legal range 2..16.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  system clock, sampled on rising edge; rst_i  in  1  synchronous reset.
REQ-007 SHALL have host ports, each an unpacked array [NrHosts]:
- host_req_i  in  1;  host_gnt_o  out  1;  host_addr_i  in  AddressWidth;  host_we_i  in  1;
- host_be_i  in  DataWidth/8;  host_wdata_i  in  DataWidth;  host_rvalid_o  out  1;  host_rdata_o  out  DataWidth;  host_err_o  out  1.
REQ-008 SHALL have device ports, each an unpacked array [NrDevices]:
- device_req_o  out  1;  device_addr_o  out  AddressWidth;  device_we_o  out  1;  device_be_o  out  DataWidth/8;  device_wdata_o  out  DataWidth;
- device_rvalid_i  in  1;  device_rdata_i  in  DataWidth;  device_err_i  in  1.
REQ-009 SHALL have cfg_device_addr_base_i and cfg_device_addr_mask_i  in  AddressWidth [NrDevices]: static address map.

Function
REQ-010 A device SHALL match when (addr & mask) == base; if several devices match, the lowest index SHALL win.
REQ-011 Arbitration SHALL be round-robin: search starts at the host index after the last granted host, wrapping to 0.
REQ-012 At most one host_gnt_o SHALL be high per cycle, and only when that host's req is high and the tracking FIFO is not full.
REQ-013 On grant, the matched device's device_req_o and the addr/we/be/wdata fields SHALL be driven combinationally in the same cycle; all other device_req_o SHALL be 0.
REQ-014 A grant to an unmapped address SHALL drive no device_req_o and SHALL push a decode-error entry.
REQ-015 Each grant SHALL push {host index, device index, decode-error flag} into the tracking FIFO.
REQ-016 Devices SHALL return responses in order, at least one cycle after their req.
REQ-017 When the FIFO head is a normal entry and device_rvalid_i of the head device is high, the fabric SHALL drive host_rvalid_o, host_rdata_o and host_err_o of the head host in that same cycle, then pop the entry.
REQ-018 When the FIFO head is a decode-error entry, the fabric SHALL assert the head host's host_rvalid_o with host_err_o=1 and host_rdata_o=0 in the first cycle that entry is at the head, then pop it.
REQ-019 device_rvalid_i from a non-head device, or with the FIFO empty, SHALL be ignored.
REQ-020 Push and pop in the same cycle SHALL be allowed; occupancy is unchanged.
REQ-021 No push SHALL occur while the FIFO is full, even if a pop happens in that cycle (no bypass).
REQ-022 host_rdata_o and host_err_o SHALL be 0 whenever host_rvalid_o is 0.
REQ-023 With all hosts requesting continuously, each host SHALL receive a grant within NrHosts consecutive grants.

Reset
REQ-024 On rst_i, the FIFO SHALL empty and the round-robin pointer SHALL reset so host 0 has priority.
REQ-025 During rst_i, all gnt, rvalid, err, rdata and device_req outputs SHALL be 0.
REQ-026 Transactions in flight at reset SHALL be dropped; late device_rvalid_i after reset SHALL be ignored per REQ-019.

Structure
REQ-027 Package soc_bus_fabric_pkg SHALL hold the tracking-entry struct type, and the clog2-derived index widths and limits.
REQ-028 The tracking FIFO SHALL be a sub-module named bus_rsp_fifo, with full and empty flags and a pointer that wraps at MaxOutstanding.

Verification
REQ-029 Two hosts request every cycle to RAM (base 0x00100000) -> grants alternate H0, H1, H0, H1...; each rvalid reaches the issuing host in order.
REQ-030 Host0 reads 0x90000000 (unmapped) -> no device_req_o; host_rvalid_o[0]=1 with err=1 and rdata=0 on the cycle after the grant.
REQ-031 A device whose responses are stalled 10 cycles, with MaxOutstanding=4 -> exactly 4 grants, then gnt=0 until the first rvalid, then one further grant.
REQ-032 Address 0x80001000 with device 3 and device 5 both mapped to it -> only device_req_o[3] is asserted.
REQ-033 rst_i asserted with 3 transactions outstanding, then a device rvalid -> all host_rvalid_o stay 0, and the first grant after reset goes to host 0.
REQ-034 Write with be=4'b0101 and wdata 0xDEADBEEF -> the device sees identical be, wdata and we=1; host_rvalid_o follows the device rvalid in the same cycle.
